fe_prefetch_unit: RTL

Parametrised instruction fetch unit with a prefetch queue. It generates sequential fetch addresses and moves instruction words from the memory port into a DEPTH-entry circular queue. It presents the oldest word and its address to decode. It supports a sticky fetch hold with explicit clear, and a redirect (jump) that flushes the queue and restarts fetch at a new target. It sits between the instruction memory port and the decode stage, replacing the single-register fe_unit.

---
 rtl/fe_prefetch_unit_pkg.sv | 21 ++
 rtl/fe_prefetch_unit_if.sv | 31 +++
 rtl/fe_prefetch_unit_queue.sv | 67 ++++++
 rtl/fe_prefetch_unit.sv | 84 ++++++++
 4 files changed

// File: rtl/fe_prefetch_unit_pkg.sv
// Shared defaults and types for the prefetching fetch unit and its users.
package fe_prefetch_unit_pkg;

  localparam int              FE_DATA_W   = 16;
  localparam int              FE_ADDR_W   = 16;
  localparam int              FE_DEPTH    = 4;
  localparam logic [15:0]     FE_RESET_PC = 16'h0000;
  localparam int              FE_PC_STEP  = 1;

  // Fetch hold state; FULL/EMPTY are derived from the queue count instead.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fe_hold_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int fe_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fe_prefetch_unit_if.sv
// Memory-side and decode-side bus of the fetch unit.
//
// Handshake rules:
//   memory : a word moves when o_req && i_rdy on a rising edge; i_data is
//            valid in that cycle and is tagged with o_addr. o_req never
//            depends combinationally on i_rdy or i_take.
//   decode : the head word is consumed when o_rdy && i_take on a rising edge;
//            i_take while o_rdy is low has no effect.
interface fe_prefetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              o_req;
  logic [ADDR_W-1:0] o_addr;
  logic              i_rdy;
  logic [DATA_W-1:0] i_data;
  logic              o_rdy;
  logic [DATA_W-1:0] o_reg;
  logic [ADDR_W-1:0] o_pc;
  logic              i_take;

  modport master (
    output o_req, o_addr, o_rdy, o_reg, o_pc,
    input  i_rdy, i_data, i_take
  );

  modport slave (
    input  o_req, o_addr, o_rdy, o_reg, o_pc,
    output i_rdy, i_data, i_take
  );
endinterface

// File: rtl/fe_prefetch_unit_queue.sv
// Circular buffer of tagged instruction words with synchronous flush.
module fe_prefetch_unit_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Pointers wrap naturally; count tells full from empty.
  assign push_ok = push && (count_q < CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign head    = mem_q[head_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy; flush empties the queue.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_ok) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // State registers; reset clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fe_prefetch_unit.sv
// Instruction fetch unit: fetch PC, sticky hold, redirect, prefetch queue.
module fe_prefetch_unit
  import fe_prefetch_unit_pkg::*;
#(
  parameter int                DATA_W   = FE_DATA_W,
  parameter int                ADDR_W   = FE_ADDR_W,
  parameter int                DEPTH    = FE_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FE_RESET_PC),
  parameter int                PC_STEP  = FE_PC_STEP
) (
  input  logic                          clk,
  input  logic                          a_rst,
  input  logic                          i_hold,
  input  logic                          i_hold_clr,
  input  logic                          i_redirect,
  input  logic [ADDR_W-1:0]             i_target,
  fe_prefetch_unit_if.master            fe,
  output logic [fe_count_w(DEPTH)-1:0]  o_count,
  output fe_hold_state_e                o_dbg_state
);
  localparam int CW = fe_count_w(DEPTH);
  localparam int EW = DATA_W + ADDR_W;

  fe_hold_state_e    state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              not_full, xfer, push, pop;

  // Request only from registered state and reset; redirect kills the push/pop.
  assign not_full    = count < CW'(DEPTH);
  assign fe.o_req    = !a_rst && (state_q == ST_RUN) && not_full;
  assign xfer        = fe.o_req && fe.i_rdy;
  assign push        = xfer && !i_redirect;
  assign pop         = fe.i_take && fe.o_rdy && !i_redirect;
  assign fe.o_addr   = pc_q;
  assign fe.o_rdy    = (count != '0);
  assign fe.o_reg    = head[EW-1:ADDR_W];
  assign fe.o_pc     = head[ADDR_W-1:0];
  assign o_count     = count;
  assign o_dbg_state = state_q;

  // Fetch PC and hold flag next state; redirect wins, hold clear beats set.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (i_redirect) begin
      pc_d = i_target;
    end else if (xfer) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
    if (i_hold_clr) begin
      state_d = ST_RUN;
    end else if (i_hold) begin
      state_d = ST_HOLD;
    end
  end

  // Fetch PC and hold state registers.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fe_prefetch_unit_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (a_rst),
    .flush     (i_redirect),
    .push      (push),
    .push_data ({fe.i_data, pc_q}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule
